// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access-size codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DONE,
        FAULT
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data shift with legality
// flags, and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            st_funct3,
    input  logic [1:0]            st_off,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [3:0]            st_be,
    output logic [DATA_WIDTH-1:0] st_wdata_sh,
    output logic                  misaligned,
    output logic                  illegal,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_off,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    assign st_wdata_sh = st_wdata << {st_off, 3'b000};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        st_be      = 4'b0000;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (st_funct3)
            F3_B, F3_BU: st_be = 4'b0001 << st_off;
            F3_H, F3_HU: begin
                st_be      = 4'b0011 << st_off;
                misaligned = st_off[0];
            end
            F3_W: begin
                st_be      = 4'b1111;
                misaligned = (st_off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    b_sel = ld_rdata[7:0];
            2'd1:    b_sel = ld_rdata[15:8];
            2'd2:    b_sel = ld_rdata[23:16];
            default: b_sel = ld_rdata[31:24];
        endcase
        h_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        case (ld_funct3)
            F3_B:    ld_data = {{(DATA_WIDTH-8){b_sel[7]}}, b_sel};
            F3_BU:   ld_data = {{(DATA_WIDTH-8){1'b0}}, b_sel};
            F3_H:    ld_data = {{(DATA_WIDTH-16){h_sel[15]}}, h_sel};
            F3_HU:   ld_data = {{(DATA_WIDTH-16){1'b0}}, h_sel};
            F3_W:    ld_data = ld_rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns execute-stage accesses into req/gnt/rvalid bus
// transactions and returns extended load data with a completion pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  wb_valid,
    output logic                  fault
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  fault_q, fault_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;

    logic                  accept;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata_sh;
    logic                  misaligned;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] ld_data;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_funct3   (funct3),
        .st_off      (ALUResult[1:0]),
        .st_wdata    (WriteData),
        .st_be       (st_be),
        .st_wdata_sh (st_wdata_sh),
        .misaligned  (misaligned),
        .illegal     (illegal),
        .ld_funct3   (f3_q),
        .ld_off      (off_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready && (MemRead || MemWrite);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        wb_valid_d  = 1'b0;
        fault_d     = 1'b0;
        f3_d        = f3_q;
        off_d       = off_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || misaligned) begin
                        state_d    = FAULT;
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;   // read+write together counts as a store
                        mem_addr_d  = {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        mem_be_d    = st_be;
                        mem_wdata_d = st_wdata_sh;
                        f3_d        = funct3;
                        off_d       = ALUResult[1:0];
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (mem_we_q) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d = WAIT_RESP;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = FAULT;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    rdata_d    = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    rdata_d    = ld_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = FAULT;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    rdata_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; every flop,
    // datapath included, is reset so the bus sees known values after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            wb_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            wb_valid_q  <= wb_valid_d;
            fault_q     <= fault_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign ReadData  = rdata_q;
    assign wb_valid  = wb_valid_q;
    assign fault     = fault_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart of the execute stage. Consumes the execute outputs: ALUResult as the address, WriteData as the store data, and the memory controls.
- Turns each access into a req/gnt/rvalid transaction on the data-memory port.
- Returns aligned, sign- or zero-extended load data to writeback.
- Stalls the pipeline through ex_ready while a transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data and address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in REQ or WAIT_RESP before a fault is raised.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  execute presents an access this cycle.
- ex_ready  output  1  unit can accept an access.
- MemRead  input  1  access is a load.
- MemWrite  input  1  access is a store.
- funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  input  DATA_WIDTH  byte address.
- WriteData  input  DATA_WIDTH  store data, right-aligned.
- mem_req  output  1  bus request.
- mem_we  output  1  bus write.
- mem_addr  output  DATA_WIDTH  word address; bits [1:0] are always 0.
- mem_be  output  4  byte enables.
- mem_wdata  output  DATA_WIDTH  lane-shifted store data.
- mem_gnt  input  1  request accepted.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  DATA_WIDTH  read word.
- ReadData  output  DATA_WIDTH  extended load result.
- wb_valid  output  1  one-cycle completion pulse.
- fault  output  1  qualifies wb_valid: misaligned, illegal funct3, or timeout.

Behaviour:
- Reset:
  - state returns to IDLE.
  - mem_req, mem_we, wb_valid and fault are 0.
  - mem_addr, mem_be, mem_wdata and ReadData are 0.
  - timeout counter is 0.
  - Asserting reset mid-transaction drops mem_req immediately; any later gnt or rvalid is ignored.
- ex_ready = 1 only in IDLE.
- An access is accepted on a clock edge where ex_valid && ex_ready && (MemRead || MemWrite). If both MemRead and MemWrite are set, the access is a store.
- Accepted access, with a = ALUResult[1:0]:
  - Illegal funct3 (011, 110, 111) or misalignment (H with a[0]=1, W with a!=0): go to FAULT. No bus activity.
  - Otherwise register the address, byte enables, shifted data and funct3, then go to REQ.
  - Byte enables: B gives be = 0001<<a. H gives be = 0011<<a. W gives be = 1111.
  - Store data: wdata = WriteData << (8*a).
- REQ: mem_req = 1, with stable address, be, we and wdata until gnt.
  - On gnt, a store goes to DONE.
  - On gnt, a load goes to WAIT_RESP.
- WAIT_RESP: mem_req = 0. On rvalid, extract lane a from mem_rdata and go to DONE:
  - B: sign-extend the selected byte.
  - BU: zero-extend the selected byte.
  - H: sign-extend the selected half.
  - HU: zero-extend the selected half.
  - W: pass the word through.
  - mem_rvalid is ignored in every other state.
- DONE: wb_valid = 1 for one cycle, fault = 0, then IDLE. ReadData is valid with wb_valid for loads and 0 for stores. ReadData holds its value until the next completion.
- FAULT: wb_valid = 1, fault = 1, ReadData = 0 for one cycle, then IDLE.
- Timeout counter:
  - Clears on entry to REQ or WAIT_RESP and increments each cycle spent there.
  - If it reaches TIMEOUT_CYCLES without gnt/rvalid, go to FAULT and deassert mem_req.
- Latency:
  - Store with gnt in the first REQ cycle: wb_valid 2 cycles after acceptance.
  - Load with gnt then rvalid the next cycle: wb_valid 3 cycles after acceptance.
- Back-to-back: a new access can be accepted in the cycle IDLE is re-entered, i.e. the cycle after wb_valid.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, REQ, WAIT_RESP, DONE, FAULT}.
- Sub-module lsu_align, combinational:
  - Computes byte enables, shifted store data and the misaligned/illegal flags.
  - Performs load lane extraction and extension.
- Top level holds the FSM, registers and timeout counter.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, mem_we=1; wb_valid 2 cycles after acceptance, fault=0.
- SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5000000.
- LB addr 0x102, rdata 0x00800000 -> ReadData=0xFFFFFF80. LBU at the same address and data -> ReadData=0x00000080. LHU addr 0x102, rdata 0xBEEF0000 -> ReadData=0x0000BEEF.
- LW addr 0x101 -> no mem_req; wb_valid=1 with fault=1 on the next cycle. funct3=011 gives the same response.
- Load with gnt held low -> mem_req stays high for 255 cycles, then wb_valid with fault=1, mem_req=0, ex_ready=1.
- rst_n pulled low in WAIT_RESP, then rvalid arrives after release -> outputs at reset values; no wb_valid; next access completes normally.
